// File: rtl/crc_apb_scheduler_pkg.sv
// crc_apb_scheduler_pkg: shared types and constants for the CRC APB scheduler.
// Holds CRC kinds, scheduler states, result masks and CRC wrapper APB addresses.
package crc_apb_scheduler_pkg;

    typedef enum logic {
        CRC8  = 1'b0,
        CRC15 = 1'b1
    } crc_kind_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_ACCESS = 3'd2,
        WAIT      = 3'd3,
        RD_SETUP  = 3'd4,
        RD_ACCESS = 3'd5,
        DONE      = 3'd6
    } sched_state_e;

    localparam logic [15:0] CRC8_MASK  = 16'h00FF;
    localparam logic [15:0] CRC15_MASK = 16'h7FFF;

    localparam logic [31:0] WRITE_CRC8  = 32'h0000_0000;
    localparam logic [31:0] READ_CRC8   = 32'h0000_0004;
    localparam logic [31:0] WRITE_CRC15 = 32'h0000_0008;
    localparam logic [31:0] READ_CRC15  = 32'h0000_000C;

    function automatic logic [31:0] wr_addr(input logic kind);
        return (kind == CRC15) ? WRITE_CRC15 : WRITE_CRC8;
    endfunction

    function automatic logic [31:0] rd_addr(input logic kind);
        return (kind == CRC15) ? READ_CRC15 : READ_CRC8;
    endfunction

    function automatic logic [15:0] crc_mask(input logic kind);
        return (kind == CRC15) ? CRC15_MASK : CRC8_MASK;
    endfunction

endpackage

// File: rtl/crc_apb_scheduler_arbiter.sv
// crc_rr_arbiter: N-way round-robin arbiter, first request at/after ptr_i wins.
// Ports: req_i (requests), ptr_i (priority start), grant_o (one-hot), idx_o, any_o.
import crc_apb_scheduler_pkg::*;

module crc_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/crc_apb_scheduler.sv
// crc_apb_scheduler: shares one CRC APB wrapper between N_REQ byte-stream requesters.
// Clients: req_valid/kind/dat/last in, req_ready out; results on res_valid/id/crc/err.
// APB master: m_adr/m_dat/m_sel/m_enable/m_we out, m_dat_i/m_ready_i in.
// Optional CRC_SCHED_TIMEOUT_EN: abort an ACCESS after TIMEOUT_CYC cycles without ready.
import crc_apb_scheduler_pkg::*;

module crc_apb_scheduler #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     p_clk_i,
    input  logic                     p_rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_kind_i,
    input  logic [8*N_REQ-1:0]       req_dat_i,
    input  logic [N_REQ-1:0]         req_last_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     res_valid_o,
    output logic [$clog2(N_REQ)-1:0] res_id_o,
    output logic [15:0]              res_crc_o,
    output logic                     res_err_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    output logic                     m_sel_o,
    output logic                     m_enable_o,
    output logic                     m_we_o,
    input  logic [31:0]              m_dat_i,
    input  logic                     m_ready_i
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("crc_apb_scheduler: unsupported N_REQ or TIMEOUT_CYC");
    end

    logic [2:0]    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] ptr_q;
    logic          kind_q;
    logic          last_q;
    logic [7:0]    byte_q;
    logic [15:0]   crc_q;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             gany;
    logic             accept;
    logic [IW-1:0]    src;
    logic [7:0]       byte_in;
    logic             is_wr;
    logic             is_rd;
    logic             in_access;
    logic             in_setup;
    logic             timeout;
    logic             unused_dat;

    assign unused_dat = ^m_dat_i[31:16];

    crc_rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // Only the owner can hand over bytes once a message is locked.
    always_comb begin
        req_ready_o = '0;
        accept      = 1'b0;
        if (!p_rst_i) begin
            if (state_q == IDLE && gany) begin
                req_ready_o = grant;
                accept      = 1'b1;
            end else if (state_q == WAIT && req_valid_i[owner_q]) begin
                req_ready_o[owner_q] = 1'b1;
                accept               = 1'b1;
            end
        end
    end

    assign src     = (state_q == IDLE) ? gidx : owner_q;
    assign byte_in = req_dat_i[8*src +: 8];

    assign is_wr     = (state_q == WR_SETUP) || (state_q == WR_ACCESS);
    assign is_rd     = (state_q == RD_SETUP) || (state_q == RD_ACCESS);
    assign in_access = (state_q == WR_ACCESS) || (state_q == RD_ACCESS);
    assign in_setup  = (state_q == WR_SETUP) || (state_q == RD_SETUP);

    assign m_sel_o    = is_wr || is_rd;
    assign m_enable_o = in_access;
    assign m_we_o     = is_wr;
    assign m_adr_o    = is_wr ? wr_addr(kind_q) :
                        is_rd ? rd_addr(kind_q) : 32'h0;
    assign m_dat_o    = is_wr ? {24'h0, byte_q} : 32'h0;

    assign res_valid_o = (state_q == DONE);
    assign res_id_o    = (state_q == DONE) ? owner_q : '0;
    assign res_crc_o   = (state_q == DONE) ? crc_q : 16'h0;

`ifdef CRC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Counts ACCESS cycles of the current transfer; fires on the last one.
    assign timeout = in_access && !m_ready_i &&
                     (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (in_setup) begin
                cnt_q <= '0;
            end else if (in_access) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (state_q == IDLE) begin
                err_q <= 1'b0;
            end
        end
    end

    assign res_err_o = (state_q == DONE) && err_q;
`else
    assign timeout   = 1'b0;
    assign res_err_o = 1'b0;
`endif

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            kind_q  <= 1'b0;
            last_q  <= 1'b0;
            byte_q  <= 8'h0;
            crc_q   <= 16'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= gidx;
                        kind_q  <= req_kind_i[gidx];
                        last_q  <= req_last_i[gidx];
                        byte_q  <= byte_in;
                        state_q <= WR_SETUP;
                    end
                end
                WR_SETUP: state_q <= WR_ACCESS;
                WR_ACCESS: begin
                    if (timeout) begin
                        crc_q   <= 16'h0;
                        state_q <= DONE;
                    end else if (m_ready_i) begin
                        state_q <= last_q ? RD_SETUP : WAIT;
                    end
                end
                WAIT: begin
                    if (accept) begin
                        last_q  <= req_last_i[owner_q];
                        byte_q  <= byte_in;
                        state_q <= WR_SETUP;
                    end
                end
                RD_SETUP: state_q <= RD_ACCESS;
                RD_ACCESS: begin
                    if (timeout) begin
                        crc_q   <= 16'h0;
                        state_q <= DONE;
                    end else if (m_ready_i) begin
                        crc_q   <= m_dat_i[15:0] & crc_mask(kind_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ptr_q   <= (owner_q == IW'(N_REQ - 1)) ? '0
                                                           : owner_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_apb_scheduler.sv
// tb_crc_apb_scheduler: directed bench with a transaction-level model and APB slave.
// Model predicts grants, APB transfers and results; literals pin key values.
import crc_apb_scheduler_pkg::*;

module tb_crc_apb_scheduler;

    localparam int N  = 2;
    localparam int TO = 64;

    logic           p_clk_i = 1'b0;
    logic           p_rst_i = 1'b1;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_kind_i = '0;
    logic [8*N-1:0] req_dat_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           res_valid_o;
    logic [0:0]     res_id_o;
    logic [15:0]    res_crc_o;
    logic           res_err_o;
    logic [31:0]    m_adr_o;
    logic [31:0]    m_dat_o;
    logic           m_sel_o;
    logic           m_enable_o;
    logic           m_we_o;
    logic [31:0]    m_dat_i = '0;
    logic           m_ready_i = 1'b0;

    always #5 p_clk_i = ~p_clk_i;

    crc_apb_scheduler #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .p_clk_i     (p_clk_i),
        .p_rst_i     (p_rst_i),
        .req_valid_i (req_valid_i),
        .req_kind_i  (req_kind_i),
        .req_dat_i   (req_dat_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .res_valid_o (res_valid_o),
        .res_id_o    (res_id_o),
        .res_crc_o   (res_crc_o),
        .res_err_o   (res_err_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_sel_o     (m_sel_o),
        .m_enable_o  (m_enable_o),
        .m_we_o      (m_we_o),
        .m_dat_i     (m_dat_i),
        .m_ready_i   (m_ready_i)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [7:0]  dat;
        logic        we;
    } xfer_t;

    int checks = 0;
    int errors = 0;

    xfer_t       expq[$];
    logic [40:0] xlog[$];
    int          res_ids[$];
    logic [15:0] res_crcs[$];
    logic        res_errs[$];
    int          enlens[$];

    bit          locked = 0;
    int          owner = 0;
    int          ptr = 0;
    logic        mkind = 0;
    bit          res_due = 0;
    logic [15:0] res_crc_exp = 0;
    logic        res_err_exp = 0;
    int          acc = 0;
    int          wcnt = 0;
    int          en_run = 0;
    int          slave_wait = 0;
    bit          slave_hang = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model and slave: expectations come from grant/lock rules and APB protocol.
    always @(negedge p_clk_i) begin
        logic [N-1:0] er;
        bit           nr;
        xfer_t        h;
        logic [31:0]  sd;
        int           r;
        er = '0;
        nr = 0;
        r  = 0;
        h  = '0;
        if (p_rst_i) begin
            expq.delete();
            locked    = 0;
            ptr       = 0;
            res_due   = 0;
            acc       = 0;
            wcnt      = 0;
            en_run    = 0;
            m_ready_i = 1'b0;
        end else begin
            if (expq.size() == 0 && !res_due) begin
                if (locked) begin
                    if (req_valid_i[owner]) er[owner] = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (er == '0 && req_valid_i[(ptr + i) % N])
                            er[(ptr + i) % N] = 1'b1;
                    end
                end
            end
            chk("req_ready", req_ready_o, er);

            chk("res_valid", res_valid_o, res_due);
            if (res_due) begin
                chk("res_id", res_id_o, owner);
                chk("res_crc", res_crc_o, res_crc_exp);
                chk("res_err", res_err_o, res_err_exp);
                res_ids.push_back(int'(res_id_o));
                res_crcs.push_back(res_crc_o);
                res_errs.push_back(res_err_o);
                res_due = 0;
                locked  = 0;
                ptr     = (owner + 1) % N;
            end

            chk("m_sel", m_sel_o, expq.size() != 0);
            chk("en_no_sel", m_enable_o & ~m_sel_o, 1'b0);
            sd = (m_adr_o == READ_CRC15) ? 32'h0000_FABC : 32'h0000_01C7;
            if (m_sel_o && expq.size() != 0) begin
                h = expq[0];
                chk("m_adr", m_adr_o, h.adr);
                chk("m_we", m_we_o, h.we);
                if (h.we) chk("m_dat", m_dat_o, {24'h0, h.dat});
                if (m_enable_o) begin
                    acc++;
                    en_run++;
                    nr = !slave_hang && (wcnt >= slave_wait);
                    wcnt++;
                    if (nr) begin
                        void'(expq.pop_front());
                        xlog.push_back({h.we, h.adr, h.we ? h.dat : 8'h0});
                        enlens.push_back(en_run);
                        en_run = 0;
                        wcnt   = 0;
                        acc    = 0;
                        if (!h.we) begin
                            res_due     = 1;
                            res_err_exp = 0;
                            res_crc_exp = mkind ? (sd[15:0] & 16'h7FFF)
                                                : (sd[15:0] & 16'h00FF);
                        end
                    end
`ifdef CRC_SCHED_TIMEOUT_EN
                    else if (acc >= TO) begin
                        expq.delete();
                        enlens.push_back(en_run);
                        en_run      = 0;
                        acc         = 0;
                        wcnt        = 0;
                        res_due     = 1;
                        res_err_exp = 1;
                        res_crc_exp = 16'h0;
                    end
`endif
                end else begin
                    acc    = 0;
                    wcnt   = 0;
                    en_run = 0;
                end
            end
            m_ready_i = nr;
            m_dat_i   = sd;

            if (er != '0) begin
                for (int i = 0; i < N; i++) if (er[i]) r = i;
                if (!locked) begin
                    locked = 1;
                    owner  = r;
                    mkind  = req_kind_i[r];
                end
                expq.push_back({mkind ? WRITE_CRC15 : WRITE_CRC8,
                                req_dat_i[8*r +: 8], 1'b1});
                if (req_last_i[r])
                    expq.push_back({mkind ? READ_CRC15 : READ_CRC8,
                                    8'h0, 1'b0});
            end
        end
    end

    task automatic send(input int r, input logic kind,
                        input logic [31:0] bytes, input int n,
                        input int gap);
        int c;
        for (int k = 0; k < n; k++) begin
            req_valid_i[r]        = 1'b1;
            req_kind_i[r]         = kind;
            req_dat_i[8*r +: 8]   = bytes[8*k +: 8];
            req_last_i[r]         = (k == n - 1);
            c = 0;
            do begin
                @(negedge p_clk_i);
                c++;
            end while (!req_ready_o[r] && c < 2000);
            chk("send_accept", req_ready_o[r], 1'b1);
            @(posedge p_clk_i);
            #1;
            req_valid_i[r] = 1'b0;
            req_last_i[r]  = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge p_clk_i);
                #1;
            end
        end
    endtask

    task automatic wait_res(input int n);
        int c;
        c = 0;
        while (res_ids.size() < n && c < 3000) begin
            @(negedge p_clk_i);
            c++;
        end
        chk("wait_res", res_ids.size(), n);
        @(posedge p_clk_i);
        #1;
    endtask

    task automatic reset_dut();
        p_rst_i = 1'b1;
        @(posedge p_clk_i);
        #1;
        p_rst_i = 1'b0;
        res_ids.delete();
        res_crcs.delete();
        res_errs.delete();
        xlog.delete();
        enlens.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        @(posedge p_clk_i);
        @(negedge p_clk_i);
        chk("rst_apb", {m_sel_o, m_enable_o, m_we_o, m_adr_o, m_dat_o}, '0);
        chk("rst_res", {res_valid_o, res_id_o, res_crc_o, res_err_o,
                        req_ready_o}, '0);
        @(posedge p_clk_i);
        #1;
        p_rst_i = 1'b0;

        // 1: CRC8 two-byte message from requester 0
        send(0, CRC8, 32'h0000_33AA, 2, 0);
        wait_res(1);
        chk("t1_nxfer", xlog.size(), 3);
        if (xlog.size() >= 3) begin
            chk("t1_wr0", xlog[0], {1'b1, 32'h0000_0000, 8'hAA});
            chk("t1_wr1", xlog[1], {1'b1, 32'h0000_0000, 8'h33});
            chk("t1_rd", xlog[2], {1'b0, 32'h0000_0004, 8'h00});
        end
        if (res_crcs.size() >= 1) begin
            chk("t1_crc", res_crcs[0], 16'h00C7);
            chk("t1_id", res_ids[0], 0);
        end

        // 2: simultaneous requesters, round-robin then wrap
        reset_dut();
        fork
            send(0, CRC15, 32'h11, 1, 0);
            send(1, CRC15, 32'h22, 1, 0);
        join
        wait_res(2);
        fork
            send(0, CRC15, 32'h33, 1, 0);
            send(1, CRC15, 32'h44, 1, 0);
        join
        wait_res(4);
        if (res_ids.size() >= 4) begin
            chk("t2_order", {res_ids[0][3:0], res_ids[1][3:0],
                             res_ids[2][3:0], res_ids[3][3:0]}, 16'h0101);
            chk("t2_crc", res_crcs[0], 16'h7ABC);
        end

        // 3: requester 1 blocked while requester 0 holds lock in WAIT
        reset_dut();
        fork
            send(0, CRC8, 32'h0000_55AA, 2, 10);
            begin
                @(posedge p_clk_i);
                #1;
                send(1, CRC8, 32'h77, 1, 0);
            end
        join
        wait_res(2);
        if (res_ids.size() >= 2)
            chk("t3_order", {res_ids[0][3:0], res_ids[1][3:0]}, 8'h01);

        // 4: three slave wait states per access
        reset_dut();
        slave_wait = 3;
        send(0, CRC15, 32'h0000_C35A, 2, 0);
        wait_res(1);
        slave_wait = 0;
        chk("t4_nxfer", xlog.size(), 3);
        if (enlens.size() >= 1) chk("t4_enlen", enlens[0], 4);

        // 5: reset during WR_ACCESS
        reset_dut();
        send(0, CRC8, 32'h01, 1, 0);
        wait_res(1);
        slave_wait = 5;
        send(1, CRC8, 32'h02, 1, 0);
        c = 0;
        while (!m_enable_o && c < 50) begin
            @(negedge p_clk_i);
            c++;
        end
        chk("t5_in_access", m_enable_o, 1'b1);
        @(posedge p_clk_i);
        #1;
        p_rst_i = 1'b1;
        @(posedge p_clk_i);
        #1;
        p_rst_i = 1'b0;
        @(negedge p_clk_i);
        chk("t5_after_rst", {m_sel_o, m_enable_o, res_valid_o}, 3'b000);
        @(posedge p_clk_i);
        #1;
        slave_wait = 0;
        res_ids.delete();
        fork
            send(0, CRC8, 32'h03, 1, 0);
            send(1, CRC8, 32'h04, 1, 0);
        join
        wait_res(2);
        if (res_ids.size() >= 2)
            chk("t5_order", {res_ids[0][3:0], res_ids[1][3:0]}, 8'h01);

        // 6: slave never ready
        reset_dut();
        slave_hang = 1;
        send(0, CRC8, 32'h99, 1, 0);
`ifdef CRC_SCHED_TIMEOUT_EN
        wait_res(1);
        slave_hang = 0;
        if (res_errs.size() >= 1) begin
            chk("t6_err", res_errs[0], 1'b1);
            chk("t6_id", res_ids[0], 0);
            chk("t6_crc", res_crcs[0], 16'h0);
        end
        if (enlens.size() >= 1) chk("t6_enlen", enlens[0], TO);
        send(1, CRC8, 32'h10, 1, 0);
        wait_res(2);
        if (res_ids.size() >= 2) chk("t6_next_id", res_ids[1], 1);
`else
        repeat (100) @(negedge p_clk_i);
        chk("t6_enable_held", m_enable_o, 1'b1);
        chk("t6_no_res", res_ids.size(), 0);
        @(posedge p_clk_i);
        #1;
        slave_hang = 0;
        reset_dut();
`endif

        repeat (3) @(posedge p_clk_i);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
